cpu_local_arb: RTL and testbench

//  Two-master AHB-lite arbiter sharing one AHB slave, the per-CPU local register block, between two requesters.
//  M0 is the CPU core data port; M1 is the debug/peer-CPU port.

---
 rtl/cpu_local_arb.sv | 163 ++++++++++++++++
 tb/tb_cpu_local_arb.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_local_arb.sv
// cpu_local_arb: two-master AHB-lite arbiter in front of the per-CPU local
// register slave. M0 is the CPU core data port, M1 the debug/peer-CPU port.
// The loser of an address phase is stalled with HREADY=0. Data-phase ownership
// is tracked so write data and read data reach the right master. Cycles with
// both masters requesting are counted in a saturating counter.
//
// Bus packing, MSB down to LSB:
//   AhbC [DATA_W+44:0] = {HADDR[31:0], HTRANS[1:0], HSIZE[2:0], HWRITE,
//                         HBURST[2:0], HPROT[3:0], HWDATA[DATA_W-1:0]}
//   AhbR [DATA_W:0]    = {HREADY, HRDATA[DATA_W-1:0]}
module cpu_local_arb #(
    parameter int RR_EN  = 1,
    parameter int CNT_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hsel_m0,
    input  logic [DATA_W+44:0]  ahbc_m0,
    output logic [DATA_W:0]     ahbr_m0,
    input  logic                hsel_m1,
    input  logic [DATA_W+44:0]  ahbc_m1,
    output logic [DATA_W:0]     ahbr_m1,
    output logic                hsel_s,
    output logic [DATA_W+44:0]  ahbc_s,
    input  logic [DATA_W:0]     ahbr_s,
    output logic [CNT_W-1:0]    conflict_cnt
);

    localparam logic [1:0] AHB_IDLE   = 2'b00;
    localparam logic [1:0] AHB_NONSEQ = 2'b10;
    localparam logic [1:0] AHB_SEQ    = 2'b11;
    localparam logic       M0         = 1'b0;
    localparam logic       M1         = 1'b1;
    localparam int         C_W        = DATA_W + 45;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        else
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]        htrans_m0;
    logic [1:0]        htrans_m1;
    logic              hready_s;
    logic [DATA_W-1:0] hrdata_s;
    logic              req0;
    logic              req1;

    // Registered arbitration state (address phase -> data phase boundary).
    logic              last_gnt_p1;
    logic              gnt_lock_p1;
    logic              gnt_hold_p1;
    logic              dp_vld_p1;
    logic              dp_mst_p1;
    logic [CNT_W-1:0]  cnt_p1;

    logic              gnt_vld;
    logic              gnt_mst;
    logic              gnt0;
    logic              gnt1;
    logic [44:0]       addr_ctl_s;
    logic [DATA_W-1:0] hwdata_s;
    logic              own0;
    logic              own1;
    logic              dp0;
    logic              dp1;
    logic              ap0;
    logic              ap1;

    assign htrans_m0 = ahbc_m0[DATA_W+12:DATA_W+11];
    assign htrans_m1 = ahbc_m1[DATA_W+12:DATA_W+11];
    assign hready_s  = ahbr_s[DATA_W];
    assign hrdata_s  = ahbr_s[DATA_W-1:0];

    // IDLE and BUSY transfers never need the slave, so they do not compete.
    assign req0 = hsel_m0 & ((htrans_m0 == AHB_NONSEQ) | (htrans_m0 == AHB_SEQ));
    assign req1 = hsel_m1 & ((htrans_m1 == AHB_NONSEQ) | (htrans_m1 == AHB_SEQ));

    // Pick at most one master; a stalled address phase keeps its grant.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_mst = M0;
        if (gnt_lock_p1 && (gnt_hold_p1 ? req1 : req0)) begin
            gnt_vld = 1'b1;
            gnt_mst = gnt_hold_p1;
        end else if (req0 && req1) begin
            gnt_vld = 1'b1;
            gnt_mst = (RR_EN != 0) ? ~last_gnt_p1 : M0;
        end else if (req0 || req1) begin
            gnt_vld = 1'b1;
            gnt_mst = req1 ? M1 : M0;
        end
    end

    assign gnt0 = gnt_vld & (gnt_mst == M0);
    assign gnt1 = gnt_vld & (gnt_mst == M1);

    // Address/control to the slave follows the grant; idle bus when nobody wins.
    always_comb begin
        addr_ctl_s = {{43{1'b0}}, AHB_IDLE};
        addr_ctl_s = '0;
        if (gnt_vld)
            addr_ctl_s = gnt_mst ? ahbc_m1[C_W-1:DATA_W] : ahbc_m0[C_W-1:DATA_W];
    end

    // Write data follows whoever owns the current data phase.
    always_comb begin
        hwdata_s = '0;
        if (dp_vld_p1)
            hwdata_s = dp_mst_p1 ? ahbc_m1[DATA_W-1:0] : ahbc_m0[DATA_W-1:0];
    end

    assign hsel_s = gnt_vld;
    assign ahbc_s = {addr_ctl_s, hwdata_s};

    assign own0 = dp_vld_p1 & (dp_mst_p1 == M0);
    assign own1 = dp_vld_p1 & (dp_mst_p1 == M1);
    assign dp0  = own0 ? hready_s : 1'b1;
    assign dp1  = own1 ? hready_s : 1'b1;
    assign ap0  = ~req0 | (gnt0 & hready_s);
    assign ap1  = ~req1 | (gnt1 & hready_s);

    assign ahbr_m0 = {dp0 & ap0, own0 ? hrdata_s : {DATA_W{1'b0}}};
    assign ahbr_m1 = {dp1 & ap1, own1 ? hrdata_s : {DATA_W{1'b0}}};

    // Accept/lock bookkeeping: advance data-phase owner when the slave is ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_p1 <= M1;
            gnt_lock_p1 <= 1'b0;
            gnt_hold_p1 <= M0;
            dp_vld_p1   <= 1'b0;
            dp_mst_p1   <= M0;
        end else if (gnt_vld) begin
            if (hready_s) begin
                last_gnt_p1 <= gnt_mst;
                dp_vld_p1   <= 1'b1;
                dp_mst_p1   <= gnt_mst;
                gnt_lock_p1 <= 1'b0;
            end else begin
                gnt_lock_p1 <= 1'b1;
                gnt_hold_p1 <= gnt_mst;
            end
        end else if (hready_s) begin
            dp_vld_p1   <= 1'b0;
            gnt_lock_p1 <= 1'b0;
        end
    end

    // Count every edge on which both masters want the slave.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_p1 <= '0;
        else if (req0 && req1)
            cnt_p1 <= sat_inc(cnt_p1);
    end

    assign conflict_cnt = cnt_p1;

endmodule

// File: tb/tb_cpu_local_arb.sv
// Bench for cpu_local_arb: a round-robin instance and a fixed-priority
// instance (both with a 4-bit contention counter) driven side by side.
module tb_cpu_local_arb;

    localparam int         CW     = 77;
    localparam int         RW     = 33;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]          hsel0, hsel1;
    logic [1:0][CW-1:0]  c0, c1;
    logic                rdy_s;
    logic [31:0]         rdata_s;
    wire  [1:0]          hsel_s;
    wire  [1:0][CW-1:0]  cs;
    wire  [1:0][RW-1:0]  rm0, rm1;
    wire  [1:0][3:0]     cnt;

    cpu_local_arb #(.RR_EN(1), .CNT_W(4)) u_rr (
        .clk(clk), .rst(rst),
        .hsel_m0(hsel0[0]), .ahbc_m0(c0[0]), .ahbr_m0(rm0[0]),
        .hsel_m1(hsel1[0]), .ahbc_m1(c1[0]), .ahbr_m1(rm1[0]),
        .hsel_s(hsel_s[0]), .ahbc_s(cs[0]), .ahbr_s({rdy_s, rdata_s}),
        .conflict_cnt(cnt[0]));

    cpu_local_arb #(.RR_EN(0), .CNT_W(4)) u_fx (
        .clk(clk), .rst(rst),
        .hsel_m0(hsel0[1]), .ahbc_m0(c0[1]), .ahbr_m0(rm0[1]),
        .hsel_m1(hsel1[1]), .ahbc_m1(c1[1]), .ahbr_m1(rm1[1]),
        .hsel_s(hsel_s[1]), .ahbc_s(cs[1]), .ahbr_s({rdy_s, rdata_s}),
        .conflict_cnt(cnt[1]));

    int n_run  = 0;
    int n_fail = 0;

    // Reference model state, per instance (0 = round-robin, 1 = fixed).
    int m_last[2], m_lock[2], m_dp[2], m_cnt[2];
    int e_gnt[2];
    bit e_req0[2], e_req1[2], e_rdy0[2], e_rdy1[2];

    bit log_en;
    int ord[2][8];
    int nord[2];

    typedef struct {
        logic h0; logic [1:0] t0; logic [31:0] a0; logic w0; logic [31:0] d0;
        logic h1; logic [1:0] t1; logic [31:0] a1; logic w1; logic [31:0] d1;
        logic rdy; logic [31:0] rdat;
        logic e_hsel; logic [31:0] e_addr; logic [31:0] e_wd;
        logic e_r0; logic e_r1; logic [31:0] e_d0; logic [31:0] e_d1; int e_cnt;
    } vec_t;
    vec_t tbl [5];

    function automatic logic [CW-1:0] mk_c(input logic [31:0] addr, input logic [1:0] tr,
                                           input logic wr, input logic [31:0] wd);
        return {addr, tr, 3'b010, wr, 3'b000, 4'b0011, wd};
    endfunction

    task automatic chk(input string name, input int d, input logic [127:0] act,
                       input logic [127:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, want %0h", name, d, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_last[d] = 1; m_lock[d] = -1; m_dp[d] = -1; m_cnt[d] = 0;
        end
    endtask

    task automatic idle_all();
        hsel0 = '0; hsel1 = '0; c0 = '0; c1 = '0;
        rdy_s = 1'b1; rdata_s = 32'h0;
    endtask

    task automatic set_m(input logic h0, input logic [31:0] a0,
                         input logic h1, input logic [31:0] a1);
        for (int d = 0; d < 2; d++) begin
            hsel0[d] = h0; c0[d] = mk_c(a0, h0 ? NONSEQ : IDLE, 1'b0, 32'h0);
            hsel1[d] = h1; c1[d] = mk_c(a1, h1 ? NONSEQ : IDLE, 1'b0, 32'h0);
        end
    endtask

    // Mid-cycle: derive expected outputs from the arbitration rules and compare.
    task automatic eval_chk();
        logic [CW-1:0] ec;
        logic [31:0]   ed0, ed1;
        #3;
        for (int d = 0; d < 2; d++) begin
            e_req0[d] = hsel0[d] && (c0[d][44:43] == 2'b10 || c0[d][44:43] == 2'b11);
            e_req1[d] = hsel1[d] && (c1[d][44:43] == 2'b10 || c1[d][44:43] == 2'b11);
            if (m_lock[d] >= 0 && (m_lock[d] == 0 ? e_req0[d] : e_req1[d])) e_gnt[d] = m_lock[d];
            else if (e_req0[d] && e_req1[d]) e_gnt[d] = (d == 0) ? 1 - m_last[d] : 0;
            else if (e_req0[d]) e_gnt[d] = 0;
            else if (e_req1[d]) e_gnt[d] = 1;
            else e_gnt[d] = -1;
            ec = '0;
            if (e_gnt[d] == 0) ec[76:32] = c0[d][76:32];
            else if (e_gnt[d] == 1) ec[76:32] = c1[d][76:32];
            if (m_dp[d] == 0) ec[31:0] = c0[d][31:0];
            else if (m_dp[d] == 1) ec[31:0] = c1[d][31:0];
            e_rdy0[d] = (m_dp[d] != 0 || rdy_s) && (!e_req0[d] || (e_gnt[d] == 0 && rdy_s));
            e_rdy1[d] = (m_dp[d] != 1 || rdy_s) && (!e_req1[d] || (e_gnt[d] == 1 && rdy_s));
            ed0 = (m_dp[d] == 0) ? rdata_s : 32'h0;
            ed1 = (m_dp[d] == 1) ? rdata_s : 32'h0;
            chk("hsel_s", d, hsel_s[d], e_gnt[d] >= 0);
            chk("ahbc_s", d, cs[d], ec);
            chk("ahbr_m0", d, rm0[d], {e_rdy0[d], ed0});
            chk("ahbr_m1", d, rm1[d], {e_rdy1[d], ed1});
            chk("conflict_cnt", d, cnt[d], m_cnt[d]);
            if (log_en && hsel_s[d] && rdy_s && nord[d] < 8) begin
                ord[d][nord[d]] = (cs[d][76:45] >= 32'h200) ? 1 : 0;
                nord[d]++;
            end
        end
    endtask

    // Advance the model across the clock edge, then move to just after it.
    task automatic adv();
        for (int d = 0; d < 2; d++) begin
            if (e_gnt[d] >= 0) begin
                if (rdy_s) begin
                    m_last[d] = e_gnt[d]; m_dp[d] = e_gnt[d]; m_lock[d] = -1;
                end else begin
                    m_lock[d] = e_gnt[d];
                end
            end else if (rdy_s) begin
                m_dp[d] = -1; m_lock[d] = -1;
            end
            if (e_req0[d] && e_req1[d]) m_cnt[d] = (m_cnt[d] >= 15) ? 15 : m_cnt[d] + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        eval_chk();
        adv();
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_table();
        for (int i = 0; i < 5; i++) begin
            for (int d = 0; d < 2; d++) begin
                hsel0[d] = tbl[i].h0; c0[d] = mk_c(tbl[i].a0, tbl[i].t0, tbl[i].w0, tbl[i].d0);
                hsel1[d] = tbl[i].h1; c1[d] = mk_c(tbl[i].a1, tbl[i].t1, tbl[i].w1, tbl[i].d1);
            end
            rdy_s = tbl[i].rdy; rdata_s = tbl[i].rdat;
            #3;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("vec%0d_hsel_s", i), d, hsel_s[d], tbl[i].e_hsel);
                chk($sformatf("vec%0d_haddr_s", i), d, cs[d][76:45], tbl[i].e_addr);
                chk($sformatf("vec%0d_hwdata_s", i), d, cs[d][31:0], tbl[i].e_wd);
                chk($sformatf("vec%0d_hready_m0", i), d, rm0[d][32], tbl[i].e_r0);
                chk($sformatf("vec%0d_hready_m1", i), d, rm1[d][32], tbl[i].e_r1);
                chk($sformatf("vec%0d_hrdata_m0", i), d, rm0[d][31:0], tbl[i].e_d0);
                chk($sformatf("vec%0d_hrdata_m1", i), d, rm1[d][31:0], tbl[i].e_d1);
                chk($sformatf("vec%0d_cnt", i), d, cnt[d], tbl[i].e_cnt);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Four back-to-back reads per master; record the order addresses are accepted.
    task automatic run_t3();
        int left0[2], left1[2];
        logic [31:0] ad0[2], ad1[2];
        for (int d = 0; d < 2; d++) begin
            left0[d] = 4; left1[d] = 4; ad0[d] = 32'h100; ad1[d] = 32'h200; nord[d] = 0;
        end
        log_en = 1'b1;
        for (int cyc = 0; cyc < 40 && (left0[0] + left1[0] + left0[1] + left1[1]) > 0; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                hsel0[d] = (left0[d] > 0);
                c0[d]    = mk_c(ad0[d], (left0[d] > 0) ? NONSEQ : IDLE, 1'b0, 32'h0);
                hsel1[d] = (left1[d] > 0);
                c1[d]    = mk_c(ad1[d], (left1[d] > 0) ? NONSEQ : IDLE, 1'b0, 32'h0);
            end
            rdy_s = 1'b1; rdata_s = $urandom;
            step();
            for (int d = 0; d < 2; d++) begin
                if (left0[d] > 0 && e_rdy0[d]) begin left0[d]--; ad0[d] += 4; end
                if (left1[d] > 0 && e_rdy1[d]) begin left1[d]--; ad1[d] += 4; end
            end
        end
        log_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("t3_reads_left", d, left0[d] + left1[d], 0);
            chk("t3_grants", d, nord[d], 8);
            for (int k = 0; k < nord[d]; k++)
                chk($sformatf("t3_order%0d", k), d, ord[d][k],
                    (d == 0) ? (k % 2) : ((k < 4) ? 0 : 1));
        end
    endtask

    // Slave stalls an M1 data phase; M1's next address holds the grant over M0.
    task automatic run_t4();
        do_reset();
        set_m(1'b0, 32'h0, 1'b1, 32'h010); rdy_s = 1'b1; step();
        set_m(1'b0, 32'h0, 1'b1, 32'h014); rdy_s = 1'b0; rdata_s = 32'h0;
        eval_chk();
        for (int d = 0; d < 2; d++) chk("t4_m1_stall", d, rm1[d][32], 1'b0);
        adv();
        for (int c = 0; c < 2; c++) begin
            set_m(1'b1, 32'h020, 1'b1, 32'h014); rdy_s = 1'b0;
            eval_chk();
            for (int d = 0; d < 2; d++) begin
                chk("t4_locked_addr", d, cs[d][76:45], 32'h014);
                chk("t4_m0_stall", d, rm0[d][32], 1'b0);
            end
            adv();
        end
        set_m(1'b1, 32'h020, 1'b1, 32'h014); rdy_s = 1'b1; rdata_s = 32'hBEEF0010;
        eval_chk();
        for (int d = 0; d < 2; d++) begin
            chk("t4_release_addr", d, cs[d][76:45], 32'h014);
            chk("t4_m1_rdata", d, rm1[d], {1'b1, 32'hBEEF0010});
            chk("t4_m0_wait", d, rm0[d][32], 1'b0);
        end
        adv();
        set_m(1'b1, 32'h020, 1'b0, 32'h0); rdy_s = 1'b1; rdata_s = 32'h0;
        eval_chk();
        for (int d = 0; d < 2; d++) begin
            chk("t4_m0_addr", d, cs[d][76:45], 32'h020);
            chk("t4_m0_go", d, rm0[d][32], 1'b1);
        end
        adv();
    endtask

    // Asynchronous reset in the middle of a contended, stalled transfer.
    task automatic run_t5();
        do_reset();
        set_m(1'b1, 32'h100, 1'b1, 32'h200); rdy_s = 1'b1; step();
        set_m(1'b1, 32'h104, 1'b1, 32'h200); rdy_s = 1'b0; rdata_s = 32'hDEAD0000;
        eval_chk();
        #1;
        rst = 1'b1;
        hsel0 = '0; hsel1 = '0; c0 = '0; c1 = '0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("t5_rst_hsel_s", d, hsel_s[d], 1'b0);
            chk("t5_rst_ahbr_m0", d, rm0[d], {1'b1, 32'h0});
            chk("t5_rst_ahbr_m1", d, rm1[d], {1'b1, 32'h0});
            chk("t5_rst_cnt", d, cnt[d], 4'h0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_m(1'b1, 32'h100, 1'b1, 32'h200); rdy_s = 1'b1;
        eval_chk();
        for (int d = 0; d < 2; d++) chk("t5_first_tie", d, cs[d][76:45], 32'h100);
        adv();
    endtask

    // 2^4+5 contention cycles must leave the 4-bit counter pinned at 0xF.
    task automatic run_t6();
        do_reset();
        for (int i = 0; i < 21; i++) begin
            set_m(1'b1, 32'h300, 1'b1, 32'h400); rdy_s = 1'b1;
            step();
        end
        idle_all();
        eval_chk();
        for (int d = 0; d < 2; d++) chk("t6_saturated", d, cnt[d], 4'hF);
        adv();
    endtask

    task automatic run_random();
        logic          h0, h1;
        logic [CW-1:0] x0, x1;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            h0 = ($urandom_range(0, 3) != 0);
            h1 = ($urandom_range(0, 3) != 0);
            x0 = mk_c($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
            x1 = mk_c($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
            for (int d = 0; d < 2; d++) begin
                hsel0[d] = h0; c0[d] = x0; hsel1[d] = h1; c1[d] = x1;
            end
            rdy_s   = ($urandom_range(0, 3) != 0);
            rdata_s = $urandom;
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //            h0 t0      a0     w0 d0             h1 t1      a1  w1 d1     rdy rdat            hsel addr    wd             r0 r1 d0             d1             cnt
        tbl[0] = '{1'b1, NONSEQ, 32'h0, 1'b0, 32'h0,      1'b1, NONSEQ, 32'h0, 1'b0, 32'h0,  1'b1, 32'h0,         1'b1, 32'h0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         0};
        tbl[1] = '{1'b0, IDLE,   32'h0, 1'b0, 32'h0,      1'b1, NONSEQ, 32'h0, 1'b0, 32'h0,  1'b1, 32'hC0DE0001,  1'b1, 32'h0, 32'h0,         1'b1, 1'b1, 32'hC0DE0001,  32'h0,         1};
        tbl[2] = '{1'b0, IDLE,   32'h0, 1'b0, 32'h0,      1'b0, IDLE,   32'h0, 1'b0, 32'h55, 1'b1, 32'h11112222,  1'b0, 32'h0, 32'h55,        1'b1, 1'b1, 32'h0,         32'h11112222,  1};
        tbl[3] = '{1'b1, NONSEQ, 32'h4, 1'b1, 32'h0,      1'b0, IDLE,   32'h0, 1'b0, 32'h0,  1'b1, 32'h0,         1'b1, 32'h4, 32'h0,         1'b1, 1'b1, 32'h0,         32'h0,         1};
        tbl[4] = '{1'b0, IDLE,   32'h0, 1'b0, 32'h12345678, 1'b0, IDLE, 32'h0, 1'b0, 32'h0,  1'b1, 32'h0,         1'b0, 32'h0, 32'h12345678,  1'b1, 1'b1, 32'h0,         32'h0,         1};

        log_en = 1'b0;
        nord[0] = 0; nord[1] = 0;
        model_reset();
        idle_all();
        rdata_s = 32'hFFFFFFFF;
        rst = 1'b1;
        @(posedge clk);
        #3;
        for (int d = 0; d < 2; d++) begin
            chk("reset_hsel_s", d, hsel_s[d], 1'b0);
            chk("reset_ahbc_s", d, cs[d], {CW{1'b0}});
            chk("reset_ahbr_m0", d, rm0[d], {1'b1, 32'h0});
            chk("reset_ahbr_m1", d, rm1[d], {1'b1, 32'h0});
            chk("reset_cnt", d, cnt[d], 4'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdata_s = 32'h0;

        run_table();
        do_reset();
        run_t3();
        run_t4();
        run_t5();
        run_t6();
        run_random();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
